neuron: RTL and testbench



---
 rtl/neuron.sv | 47 ++++
 tb/tb_neuron.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron.sv
// Single integrate-and-fire neuron: masked weighted sum of the active input lanes,
// compared against a fixed threshold, with the fire decision held in one flop.
module neuron #(
  parameter int NUM_SPIKES = 8,
  parameter int WBITS      = 3,
  parameter int THRESHOLD  = 8,
  localparam int SUMW      = WBITS + $clog2(NUM_SPIKES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SPIKES-1:0]       spikes_in,
  input  logic [NUM_SPIKES*WBITS-1:0] weights,
  output logic [SUMW-1:0]             sum,
  output logic                        spikes_out
);

  localparam logic [SUMW-1:0] THRESH_W = SUMW'(THRESHOLD);

  logic [WBITS-1:0] masked [NUM_SPIKES];
  logic             fire;

  // Lanes without a spike contribute zero; the weight is gated, not the sum.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPIKES; gi++) begin : g_lane
      assign masked[gi] = spikes_in[gi] ? weights[gi*WBITS +: WBITS] : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      sum = sum + SUMW'(masked[i]);
    end
  end

  assign fire = (sum >= THRESH_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spikes_out <= 1'b0;
    end else begin
      spikes_out <= fire;
    end
  end

endmodule

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: directed threshold/boundary cases, asynchronous
// reset behaviour and a randomized sweep against a plain-arithmetic reference.
module tb_neuron;

  localparam int NS   = 8;
  localparam int WB   = 3;
  localparam int TH   = 8;
  localparam int SW   = WB + $clog2(NS + 1);

  logic              clk;
  logic              rst_n;
  logic [NS-1:0]     spikes_in;
  logic [NS*WB-1:0]  weights;
  logic [SW-1:0]     sum;
  logic              spikes_out;

  int tests_run;
  int tests_failed;

  neuron #(.NUM_SPIKES(NS), .WBITS(WB), .THRESHOLD(TH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spikes_in  (spikes_in),
    .weights    (weights),
    .sum        (sum),
    .spikes_out (spikes_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: add up the weight of every lane whose spike bit is set.
  function automatic int ref_sum(input logic [NS-1:0] spk, input logic [NS*WB-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < NS; i++) begin
      if (spk[i]) s += int'(w[i*WB +: WB]);
    end
    return s;
  endfunction

  // Inputs change 1 time unit after a rising edge.
  task automatic drive_after_edge(input logic [NS-1:0] spk, input logic [NS*WB-1:0] w);
    @(posedge clk);
    #1;
    spikes_in = spk;
    weights   = w;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    spikes_in = '0;
    weights   = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (spikes_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: spikes_out=%b required 0", spikes_out);
    end
    // Still in reset with firing inputs: output must stay low across an edge.
    spikes_in = '1;
    weights   = '1;
    @(posedge clk);
    #1;
    tests_run++;
    if (spikes_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hold: spikes_out=%b required 0", spikes_out);
    end
    #2 rst_n = 1'b1;
    #1;
    tests_run++;
    if (spikes_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_no_edge: spikes_out=%b required 0", spikes_out);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (spikes_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_edge_after_release: spikes_out=%b required 1", spikes_out);
    end
    // Mid-cycle assertion clears the output without waiting for a clock edge.
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (spikes_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_clear: spikes_out=%b required 0", spikes_out);
    end
    tests_run++;
    if (sum !== SW'(56)) begin
      tests_failed++;
      $display("FAIL sum_during_reset: sum=%0d required 56", sum);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (spikes_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_clear_hold: spikes_out=%b required 0", spikes_out);
    end
    #2 rst_n = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_directed(input string name, input logic [NS-1:0] spk,
                               input logic [NS*WB-1:0] w, input int exp_sum,
                               input logic exp_fire);
    drive_after_edge(spk, w);
    #1;
    tests_run++;
    if (sum !== SW'(exp_sum)) begin
      tests_failed++;
      $display("FAIL %s_sum: sum=%0d required %0d", name, sum, exp_sum);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (spikes_out !== exp_fire) begin
      tests_failed++;
      $display("FAIL %s_fire: spikes_out=%b required %b", name, spikes_out, exp_fire);
    end
    $display("[TB] %s spikes_in=%b sum=%0d spikes_out=%b", name, spk, sum, spikes_out);
  endtask

  task automatic test_zero_spikes();
    test_directed("zero_spikes", 8'h00, {NS{3'd7}}, 0, 1'b0);
  endtask

  task automatic test_exact_threshold();
    test_directed("exact_threshold", 8'b0000_0011, {{6{3'd7}}, 3'd5, 3'd3}, 8, 1'b1);
  endtask

  task automatic test_below_threshold();
    test_directed("below_threshold", 8'b0000_0011, {{6{3'd7}}, 3'd4, 3'd3}, 7, 1'b0);
  endtask

  task automatic test_max_sum();
    test_directed("max_sum", 8'hFF, {NS{3'd7}}, 56, 1'b1);
  endtask

  task automatic test_zero_weight_lane();
    test_directed("zero_weight_lane", 8'b1000_0001, {3'd0, {6{3'd7}}, 3'd7}, 7, 1'b0);
  endtask

  // Each step sets one more random spike bit and one more random weight bit;
  // a sweep restarts from all-zero once several bits are in.
  task automatic test_random_sweep();
    logic [NS-1:0]    spk;
    logic [NS*WB-1:0] w;
    int               exp_s;
    logic             prev_fire;
    spk = '0;
    w   = '0;
    drive_after_edge(spk, w);
    prev_fire = (ref_sum(spk, w) >= TH);
    for (int step = 0; step < 120; step++) begin
      if (step % 30 == 0) begin
        spk = '0;
        w   = '0;
      end
      spk[$urandom_range(NS - 1, 0)]      = 1'b1;
      w[$urandom_range(NS * WB - 1, 0)]   = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if (spikes_out !== prev_fire) begin
        tests_failed++;
        $display("FAIL sweep_fire step %0d: spikes_out=%b required %b", step, spikes_out, prev_fire);
      end
      spikes_in = spk;
      weights   = w;
      exp_s     = ref_sum(spk, w);
      #1;
      tests_run++;
      if (sum !== SW'(exp_s)) begin
        tests_failed++;
        $display("FAIL sweep_sum step %0d: sum=%0d required %0d", step, sum, exp_s);
      end
      prev_fire = (exp_s >= TH);
      $display("[TB] sweep %0d spikes_in=%b weights=%h sum=%0d", step, spk, w, sum);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (spikes_out !== prev_fire) begin
      tests_failed++;
      $display("FAIL sweep_fire_last: spikes_out=%b required %b", spikes_out, prev_fire);
    end
  endtask

  // Fully random vectors changing every cycle, checking one-cycle latency.
  task automatic test_back_to_back();
    logic [NS-1:0]    spk;
    logic [NS*WB-1:0] w;
    int               exp_s;
    logic             prev_fire;
    prev_fire = 1'bx;
    for (int step = 0; step < 60; step++) begin
      spk = NS'($urandom);
      w   = (NS*WB)'($urandom);
      @(posedge clk);
      #1;
      if (step > 0) begin
        tests_run++;
        if (spikes_out !== prev_fire) begin
          tests_failed++;
          $display("FAIL b2b_fire step %0d: spikes_out=%b required %b", step, spikes_out, prev_fire);
        end
      end
      spikes_in = spk;
      weights   = w;
      exp_s     = ref_sum(spk, w);
      #1;
      tests_run++;
      if (sum !== SW'(exp_s)) begin
        tests_failed++;
        $display("FAIL b2b_sum step %0d: sum=%0d required %0d", step, sum, exp_s);
      end
      prev_fire = (exp_s >= TH);
      $display("[TB] b2b %0d spikes_in=%b weights=%h sum=%0d", step, spk, w, sum);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_zero_spikes();
    test_exact_threshold();
    test_below_threshold();
    test_max_sum();
    test_zero_weight_lane();
    test_random_sweep();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
